// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - data-cache miss handshake between the stall controller and the memory side
interface pipe_stall_ctrl_if;
   logic dmem_access_i;
   logic dcache_hit_i;
   logic dcache_dirty_i;
   logic mem_ack_i;
   logic mem_req_o;
   logic mem_we_o;
   logic refill_o;

   modport master (
      input  dmem_access_i,
      input  dcache_hit_i,
      input  dcache_dirty_i,
      input  mem_ack_i,
      output mem_req_o,
      output mem_we_o,
      output refill_o
   );

   modport slave (
      output dmem_access_i,
      output dcache_hit_i,
      output dcache_dirty_i,
      output mem_ack_i,
      input  mem_req_o,
      input  mem_we_o,
      input  refill_o
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - cache-miss FSM, load-use/branch hazard control and stall counters
module pipe_stall_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              IDEX_MemRead_i,
   input  logic [REG_AW-1:0] IDEX_RDaddr_i,
   input  logic [REG_AW-1:0] IFID_RS1addr_i,
   input  logic [REG_AW-1:0] IFID_RS2addr_i,
   input  logic              branch_taken_i,
   pipe_stall_ctrl_if.master mem_if,
   output logic              mem_stall_o,
   output logic              pc_write_o,
   output logic              ifid_write_o,
   output logic              idex_bubble_o,
   output logic              ifid_flush_o,
   output logic [1:0]        state_o,
   output logic [CNT_W-1:0]  miss_cnt_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      WB     = 2'b01,
      REFILL = 2'b10,
      DONE   = 2'b11
   } state_e;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             miss;
   logic             lu;

   always_comb begin
      miss = start_i & mem_if.dmem_access_i & ~mem_if.dcache_hit_i;
      lu   = start_i & IDEX_MemRead_i & (IDEX_RDaddr_i != '0) &
             ((IDEX_RDaddr_i == IFID_RS1addr_i) | (IDEX_RDaddr_i == IFID_RS2addr_i));

      state_d = state_q;
      unique case (state_q)
         IDLE:    if (miss) state_d = mem_if.dcache_dirty_i ? WB : REFILL;
         WB:      if (mem_if.mem_ack_i) state_d = REFILL;
         REFILL:  if (mem_if.mem_ack_i) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are qualified by rst_i so an asserted reset silences them within the cycle.
      mem_if.mem_req_o = rst_i & ((state_q == WB) | (state_q == REFILL));
      mem_if.mem_we_o  = rst_i & (state_q == WB);
      mem_if.refill_o  = rst_i & (state_q == REFILL) & mem_if.mem_ack_i;
      mem_stall_o      = rst_i & (((state_q == IDLE) & miss) | (state_q == WB) | (state_q == REFILL));

      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b0;
      ifid_flush_o  = 1'b0;
      if (!rst_i || !start_i || mem_stall_o) begin
         pc_write_o = 1'b0;
      end else if (lu) begin
         idex_bubble_o = 1'b1;
      end else begin
         pc_write_o   = 1'b1;
         ifid_write_o = 1'b1;
         ifid_flush_o = branch_taken_i;
      end

      miss_cnt_d = miss_cnt_q;
      if ((state_q == IDLE) && miss && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_ONE;

      stall_cnt_d = stall_cnt_q;
      if ((mem_stall_o || lu) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         miss_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         miss_cnt_q  <= miss_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign state_o     = state_q;
   assign miss_cnt_o  = miss_cnt_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed bench for pipe_stall_ctrl with an 8-bit counter configuration
module tb_pipe_stall_ctrl;
   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       start_i;
   logic       IDEX_MemRead_i;
   logic [4:0] IDEX_RDaddr_i;
   logic [4:0] IFID_RS1addr_i;
   logic [4:0] IFID_RS2addr_i;
   logic       branch_taken_i;
   logic       mem_stall_o;
   logic       pc_write_o;
   logic       ifid_write_o;
   logic       idex_bubble_o;
   logic       ifid_flush_o;
   logic [1:0] state_o;
   logic [7:0] miss_cnt_o;
   logic [7:0] stall_cnt_o;

   int checks = 0;
   int errors = 0;

   pipe_stall_ctrl_if mif ();

   pipe_stall_ctrl #(.REG_AW(5), .CNT_W(8)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .IDEX_MemRead_i (IDEX_MemRead_i),
      .IDEX_RDaddr_i  (IDEX_RDaddr_i),
      .IFID_RS1addr_i (IFID_RS1addr_i),
      .IFID_RS2addr_i (IFID_RS2addr_i),
      .branch_taken_i (branch_taken_i),
      .mem_if         (mif),
      .mem_stall_o    (mem_stall_o),
      .pc_write_o     (pc_write_o),
      .ifid_write_o   (ifid_write_o),
      .idex_bubble_o  (idex_bubble_o),
      .ifid_flush_o   (ifid_flush_o),
      .state_o        (state_o),
      .miss_cnt_o     (miss_cnt_o),
      .stall_cnt_o    (stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Hazard vector is {pc_write, ifid_write, idex_bubble, ifid_flush}.
   task automatic chk_haz(input string tag, input int exp);
      chk(tag, int'({pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o}), exp);
   endtask

   // Memory vector is {mem_req, mem_we, refill, mem_stall}.
   task automatic chk_mem(input string tag, input int exp);
      chk(tag, int'({mif.mem_req_o, mif.mem_we_o, mif.refill_o, mem_stall_o}), exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i = 1'b0;
      start_i = 1'b1;
      IDEX_MemRead_i = 1'b1;
      IDEX_RDaddr_i = 5'd5;
      IFID_RS1addr_i = 5'd5;
      IFID_RS2addr_i = 5'd0;
      branch_taken_i = 1'b1;
      mif.dmem_access_i = 1'b1;
      mif.dcache_hit_i = 1'b0;
      mif.dcache_dirty_i = 1'b0;
      mif.mem_ack_i = 1'b0;
      #1;
      chk("rst_state", int'(state_o), 0);
      chk_mem("rst_mem", 0);
      chk_haz("rst_haz", 0);
      tick();
      chk("rst_miss_cnt", int'(miss_cnt_o), 0);
      chk("rst_stall_cnt", int'(stall_cnt_o), 0);

      // Release reset with a miss pending: no transition before the next edge.
      IDEX_MemRead_i = 1'b0;
      branch_taken_i = 1'b0;
      rst_i = 1'b1;
      #1;
      chk("release_state", int'(state_o), 0);
      chk_mem("release_mem", 4'b0001);
      chk_haz("release_haz", 0);

      // Clean miss: IDLE -> REFILL -> DONE -> IDLE, ack on the 4th stall cycle.
      tick();
      chk("clean_refill", int'(state_o), 2);
      chk_mem("clean_refill_mem", 4'b1001);
      tick();
      chk_mem("clean_refill_mem2", 4'b1001);
      tick();
      mif.mem_ack_i = 1'b1;
      #1;
      chk_mem("clean_refill_pulse", 4'b1011);
      tick();
      mif.mem_ack_i = 1'b0;
      mif.dcache_hit_i = 1'b1;
      #1;
      chk("clean_done", int'(state_o), 3);
      chk_mem("clean_done_mem", 0);
      chk_haz("clean_done_haz", 4'b1100);
      chk("clean_miss_cnt", int'(miss_cnt_o), 1);
      chk("clean_stall_cnt", int'(stall_cnt_o), 4);
      mif.mem_ack_i = 1'b1;
      tick();
      mif.mem_ack_i = 1'b0;
      chk("clean_idle", int'(state_o), 0);
      chk("clean_miss_cnt_hold", int'(miss_cnt_o), 1);

      // Dirty miss: IDLE -> WB -> REFILL -> DONE -> IDLE.
      mif.dcache_hit_i = 1'b0;
      mif.dcache_dirty_i = 1'b1;
      #1;
      chk_mem("dirty_idle_mem", 4'b0001);
      tick();
      chk("dirty_wb", int'(state_o), 1);
      chk_mem("dirty_wb_mem", 4'b1101);
      tick();
      mif.mem_ack_i = 1'b1;
      #1;
      chk_mem("dirty_wb_ack_mem", 4'b1101);
      tick();
      mif.mem_ack_i = 1'b0;
      #1;
      chk("dirty_refill", int'(state_o), 2);
      chk_mem("dirty_refill_mem", 4'b1001);
      mif.mem_ack_i = 1'b1;
      #1;
      chk_mem("dirty_refill_pulse", 4'b1011);
      tick();
      mif.mem_ack_i = 1'b0;
      mif.dcache_hit_i = 1'b1;
      #1;
      chk("dirty_done", int'(state_o), 3);
      chk_mem("dirty_done_mem", 0);
      chk("dirty_miss_cnt", int'(miss_cnt_o), 2);
      chk("dirty_stall_cnt", int'(stall_cnt_o), 8);
      tick();
      chk("dirty_idle", int'(state_o), 0);
      mif.dmem_access_i = 1'b0;
      mif.dcache_dirty_i = 1'b0;
      mif.dcache_hit_i = 1'b0;

      // Load-use on RS2, then x0 destination must not stall.
      IDEX_MemRead_i = 1'b1;
      IDEX_RDaddr_i = 5'd5;
      IFID_RS1addr_i = 5'd3;
      IFID_RS2addr_i = 5'd5;
      #1;
      chk_haz("lu_bubble", 4'b0010);
      chk_mem("lu_mem", 0);
      tick();
      chk("lu_stall_cnt", int'(stall_cnt_o), 9);
      IDEX_MemRead_i = 1'b0;
      #1;
      chk_haz("lu_clear", 4'b1100);
      IDEX_MemRead_i = 1'b1;
      IDEX_RDaddr_i = 5'd0;
      IFID_RS1addr_i = 5'd0;
      IFID_RS2addr_i = 5'd0;
      #1;
      chk_haz("lu_x0", 4'b1100);
      tick();
      chk("lu_x0_cnt", int'(stall_cnt_o), 9);

      // Branch flush, then gated by start_i.
      IDEX_MemRead_i = 1'b0;
      branch_taken_i = 1'b1;
      #1;
      chk_haz("branch_flush", 4'b1101);
      start_i = 1'b0;
      #1;
      chk_haz("nostart_haz", 0);
      start_i = 1'b1;

      // Miss, load-use and branch together: the memory stall wins.
      IDEX_MemRead_i = 1'b1;
      IDEX_RDaddr_i = 5'd5;
      IFID_RS2addr_i = 5'd5;
      mif.dmem_access_i = 1'b1;
      #1;
      chk_mem("prio_mem", 4'b0001);
      chk_haz("prio_haz", 0);
      tick();
      mif.mem_ack_i = 1'b1;
      tick();
      mif.mem_ack_i = 1'b0;
      mif.dcache_hit_i = 1'b1;
      #1;
      chk("prio_done", int'(state_o), 3);
      chk_haz("prio_done_haz", 4'b0010);
      chk("prio_stall_cnt", int'(stall_cnt_o), 11);
      chk("prio_miss_cnt", int'(miss_cnt_o), 3);
      tick();
      IDEX_MemRead_i = 1'b0;
      branch_taken_i = 1'b0;
      mif.dmem_access_i = 1'b0;
      mif.dcache_hit_i = 1'b0;

      // start_i drops during WB: transaction continues, hazards gated.
      mif.dmem_access_i = 1'b1;
      mif.dcache_dirty_i = 1'b1;
      tick();
      start_i = 1'b0;
      #1;
      chk("nostart_wb", int'(state_o), 1);
      chk_mem("nostart_wb_mem", 4'b1101);
      mif.mem_ack_i = 1'b1;
      tick();
      chk("nostart_refill", int'(state_o), 2);

      // Asynchronous reset mid-REFILL with ack high: no refill pulse, ack ignored afterwards.
      rst_i = 1'b0;
      #1;
      chk_mem("rst_mid_mem", 0);
      chk("rst_mid_state", int'(state_o), 0);
      chk("rst_mid_miss_cnt", int'(miss_cnt_o), 0);
      chk("rst_mid_stall_cnt", int'(stall_cnt_o), 0);
      tick();
      rst_i = 1'b1;
      start_i = 1'b1;
      mif.dmem_access_i = 1'b0;
      mif.dcache_dirty_i = 1'b0;
      tick();
      mif.mem_ack_i = 1'b0;
      chk("late_ack_state", int'(state_o), 0);
      chk_mem("late_ack_mem", 0);

      // Saturation of the 8-bit stall counter under a persistent load-use.
      IDEX_MemRead_i = 1'b1;
      IDEX_RDaddr_i = 5'd7;
      IFID_RS1addr_i = 5'd7;
      repeat (300) tick();
      chk("sat_stall_cnt", int'(stall_cnt_o), 255);
      repeat (200) tick();
      chk("sat_stall_hold", int'(stall_cnt_o), 255);
      chk_haz("sat_haz", 4'b0010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- REG_AW, 5, register address width.
- CNT_W, 16, performance counter width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, single clock.
- rst_i, in, 1, reset; asynchronous, active-low.
- start_i, in, 1, pipeline enable.
- IDEX_MemRead_i, in, 1, load in EX.
- IDEX_RDaddr_i, in, REG_AW, load destination.
- IFID_RS1addr_i, in, REG_AW, ID source 1.
- IFID_RS2addr_i, in, REG_AW, ID source 2.
- branch_taken_i, in, 1, branch resolved taken in ID.
- dmem_access_i, in, 1, MEM-stage load/store valid.
- dcache_hit_i, in, 1, MEM-stage cache hit.
- dcache_dirty_i, in, 1, victim line dirty.
- mem_ack_i, in, 1, one-cycle off-chip completion pulse.
- mem_req_o, out, 1, off-chip request.
- mem_we_o, out, 1, request is write-back.
- refill_o, out, 1, write refill line into cache.
- mem_stall_o, out, 1, freeze all pipeline registers.
- pc_write_o, out, 1, PC update enable.
- ifid_write_o, out, 1, IF/ID update enable.
- idex_bubble_o, out, 1, zero ID/EX control inputs.
- ifid_flush_o, out, 1, clear IF/ID.
- state_o, out, 2, FSM state.
- miss_cnt_o, out, CNT_W, miss count.
- stall_cnt_o, out, CNT_W, stall-cycle count.

Function
REQ-003 The FSM SHALL have states IDLE=00, WB=01, REFILL=10, DONE=11, with state_o equal to the current state.

REQ-004 The miss condition SHALL be miss = start_i & dmem_access_i & ~dcache_hit_i.

REQ-005 FSM transitions SHALL be:
- IDLE with miss goes to WB if dcache_dirty_i, else to REFILL.
- WB with mem_ack_i goes to REFILL.
- REFILL with mem_ack_i goes to DONE.
- DONE goes to IDLE unconditionally.
- All other cases hold the current state.

REQ-006 mem_req_o SHALL be 1 exactly in WB and REFILL; mem_we_o SHALL be 1 exactly in WB.

REQ-007 refill_o SHALL be 1 only in the cycle when state is REFILL and mem_ack_i is 1.

REQ-008 mem_ack_i SHALL be ignored in IDLE and DONE.

REQ-009 mem_stall_o SHALL be combinational: (IDLE & miss) | WB | REFILL; it SHALL be 0 in DONE so the access replays as a hit.

REQ-010 The load-use condition SHALL be lu = start_i & IDEX_MemRead_i & (IDEX_RDaddr_i != 0) & (IDEX_RDaddr_i == IFID_RS1addr_i | IDEX_RDaddr_i == IFID_RS2addr_i).

REQ-011 Hazard output priority SHALL be, highest first:
- ~start_i: pc_write_o=0, ifid_write_o=0, idex_bubble_o=0, ifid_flush_o=0.
- mem_stall_o: pc_write_o=0, ifid_write_o=0, idex_bubble_o=0, ifid_flush_o=0.
- lu: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0.
- Otherwise: pc_write_o=1, ifid_write_o=1, idex_bubble_o=0, ifid_flush_o=branch_taken_i.

REQ-012 miss_cnt_o SHALL increment by 1 on each IDLE-to-WB or IDLE-to-REFILL transition, saturating at all-ones.

REQ-013 stall_cnt_o SHALL increment by 1 in each cycle with mem_stall_o | lu, saturating at all-ones.

REQ-014 When start_i falls while in WB or REFILL, the FSM SHALL complete the transaction; only the hazard outputs are gated.

Reset
REQ-015 While rst_i=0, asynchronously, the block SHALL hold:
- state = IDLE;
- miss_cnt_o = 0 and stall_cnt_o = 0;
- mem_req_o, mem_we_o, refill_o, mem_stall_o, idex_bubble_o, ifid_flush_o = 0;
- pc_write_o = 0 and ifid_write_o = 0.

REQ-016 Reset asserted mid-transaction SHALL drop mem_req_o within the same cycle, with no refill_o pulse.

REQ-017 The first FSM transition after rst_i rises SHALL occur no earlier than the next clk_i rising edge.

Verification
REQ-018 Clean miss: dmem_access_i=1, dcache_hit_i=0, dcache_dirty_i=0; mem_ack_i pulsed 3 cycles later -> required response:
- state 00->10->11->00;
- mem_stall_o high for 4 cycles;
- refill_o pulses once;
- miss_cnt_o=1.

REQ-019 Dirty miss: two acks -> required response:
- state path is IDLE-WB-REFILL-DONE-IDLE;
- mem_we_o=1 only in WB;
- mem_req_o is continuous across WB and REFILL.

REQ-020 Load-use: IDEX_MemRead_i=1, IDEX_RDaddr_i=5, IFID_RS2addr_i=5 -> required response: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 for one cycle. Repeating with IDEX_RDaddr_i=0 -> no stall.

REQ-021 Priority: miss + lu + branch_taken_i asserted together -> required response:
- mem_stall_o=1, idex_bubble_o=0, ifid_flush_o=0.
- After DONE, with lu still asserted: bubble only, no flush.

REQ-022 Reset mid-REFILL -> required response: mem_req_o=0 immediately, state_o=00, counters=0, and a late mem_ack_i is ignored.

REQ-023 Saturation: preload 500 stall cycles with CNT_W=8 -> required response: stall_cnt_o=255 and holds at 255.
